// File: rtl/tim3_arb_pkg.sv
// Shared types and constants for the TIM3 two-requester APB arbiter.
package tim3_arb_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned PROT_W       = 3;
  localparam int unsigned PPROT_NS_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_REJ
  } state_e;

endpackage

// File: rtl/tim3_apb_arb_if.sv
// Bundle of both requester APB ports and the downstream timer APB port.
interface tim3_apb_arb_if;
  import tim3_arb_pkg::*;

  logic              m0_psel, m0_penable, m0_pwrite;
  logic [ADDR_W-1:0] m0_paddr;
  logic [DATA_W-1:0] m0_pwdata;
  logic [PROT_W-1:0] m0_pprot;
  logic [DATA_W-1:0] m0_prdata;
  logic              m0_pready, m0_pslverr;

  logic              m1_psel, m1_penable, m1_pwrite;
  logic [ADDR_W-1:0] m1_paddr;
  logic [DATA_W-1:0] m1_pwdata;
  logic [PROT_W-1:0] m1_pprot;
  logic [DATA_W-1:0] m1_prdata;
  logic              m1_pready, m1_pslverr;

  logic              tim_psel, tim_penable, tim_pwrite;
  logic [ADDR_W-1:0] tim_paddr;
  logic [DATA_W-1:0] tim_pwdata;
  logic [DATA_W-1:0] tim_prdata;

  // Arbiter view
  modport slave (
    input  m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata, m0_pprot,
    input  m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_pprot,
    input  tim_prdata,
    output m0_prdata, m0_pready, m0_pslverr,
    output m1_prdata, m1_pready, m1_pslverr,
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata
  );

  // Environment view (requesters and timer)
  modport master (
    output m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata, m0_pprot,
    output m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_pprot,
    output tim_prdata,
    input  m0_prdata, m0_pready, m0_pslverr,
    input  m1_prdata, m1_pready, m1_pslverr,
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata
  );

endinterface

// File: rtl/tim3_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module tim3_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tim3_apb_arb.sv
// Arbitrates two APB requesters onto the TIM3 timer, rejecting non-secure accesses
// when the timer is marked secure-only.
module tim3_apb_arb
  import tim3_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] REJ_RDATA = 32'h0000_0000
) (
  input  logic pclk,
  input  logic presetn,
  input  logic tipc_tim3_trust,
  tim3_apb_arb_if.slave bus
);

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    pwrite_q, pwrite_d;

  logic                    tim_psel_q, tim_psel_d;
  logic                    tim_penable_q, tim_penable_d;
  logic                    tim_pwrite_q, tim_pwrite_d;
  logic [ADDR_W-1:0]       tim_paddr_q, tim_paddr_d;
  logic [DATA_W-1:0]       tim_pwdata_q, tim_pwdata_d;

  logic [1:0]              pready_q, pready_d;
  logic [1:0]              pslverr_q, pslverr_d;
  logic [1:0][DATA_W-1:0]  prdata_q, prdata_d;

  logic [1:0]              req, grant;
  logic                    win, win_wr, win_ns;
  logic [ADDR_W-1:0]       win_addr;
  logic [DATA_W-1:0]       win_wdata;

  assign req = {bus.m1_psel, bus.m0_psel};

  tim3_arb_rr u_rr (
    .req        (req),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Winner's request fields, muxed by the one-hot grant
  assign win       = grant[1];
  assign win_addr  = win ? bus.m1_paddr  : bus.m0_paddr;
  assign win_wdata = win ? bus.m1_pwdata : bus.m0_pwdata;
  assign win_wr    = win ? bus.m1_pwrite : bus.m0_pwrite;
  assign win_ns    = win ? bus.m1_pprot[PPROT_NS_BIT] : bus.m0_pprot[PPROT_NS_BIT];

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pwrite_d      = pwrite_q;
    tim_psel_d    = 1'b0;
    tim_penable_d = 1'b0;
    tim_pwrite_d  = 1'b0;
    tim_paddr_d   = '0;
    tim_pwdata_d  = '0;
    pready_d      = 2'b00;
    pslverr_d     = 2'b00;
    prdata_d      = prdata_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          gnt_d    = win;
          last_d   = win;
          addr_d   = win_addr;
          wdata_d  = win_wdata;
          pwrite_d = win_wr;
          // Trust is only looked at here; later changes do not touch this transfer
          if (tipc_tim3_trust && win_ns) begin
            state_d        = ST_REJ;
            pready_d[win]  = 1'b1;
            pslverr_d[win] = 1'b1;
            prdata_d[win]  = REJ_RDATA;
          end else begin
            state_d      = ST_SETUP;
            tim_psel_d   = 1'b1;
            tim_paddr_d  = win_addr;
            tim_pwdata_d = win_wdata;
            tim_pwrite_d = win_wr;
          end
        end
      end
      ST_SETUP: begin
        state_d       = ST_ACCESS;
        tim_psel_d    = 1'b1;
        tim_penable_d = 1'b1;
        tim_paddr_d   = addr_q;
        tim_pwdata_d  = wdata_q;
        tim_pwrite_d  = pwrite_q;
      end
      ST_ACCESS: begin
        // Timer has no wait states: its read data is valid at the end of ACCESS
        state_d         = ST_DONE;
        pready_d[gnt_q] = 1'b1;
        prdata_d[gnt_q] = pwrite_q ? '0 : bus.tim_prdata;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_REJ:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      pwrite_q      <= 1'b0;
      tim_psel_q    <= 1'b0;
      tim_penable_q <= 1'b0;
      tim_pwrite_q  <= 1'b0;
      tim_paddr_q   <= '0;
      tim_pwdata_q  <= '0;
      pready_q      <= 2'b00;
      pslverr_q     <= 2'b00;
      prdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      pwrite_q      <= pwrite_d;
      tim_psel_q    <= tim_psel_d;
      tim_penable_q <= tim_penable_d;
      tim_pwrite_q  <= tim_pwrite_d;
      tim_paddr_q   <= tim_paddr_d;
      tim_pwdata_q  <= tim_pwdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      prdata_q      <= prdata_d;
    end
  end

  assign bus.tim_psel    = tim_psel_q;
  assign bus.tim_penable = tim_penable_q;
  assign bus.tim_pwrite  = tim_pwrite_q;
  assign bus.tim_paddr   = tim_paddr_q;
  assign bus.tim_pwdata  = tim_pwdata_q;
  assign bus.m0_pready   = pready_q[0];
  assign bus.m0_pslverr  = pslverr_q[0];
  assign bus.m0_prdata   = prdata_q[0];
  assign bus.m1_pready   = pready_q[1];
  assign bus.m1_pslverr  = pslverr_q[1];
  assign bus.m1_prdata   = prdata_q[1];

endmodule

// File: tb/tb_tim3_apb_arb.sv
// Self-checking bench for tim3_apb_arb: directed and randomized transfers against a transaction-level model.
module tb_tim3_apb_arb;
  import tim3_arb_pkg::*;

  localparam logic [31:0] REJ_VAL = 32'hBAD0_0BAD;

  logic pclk = 1'b0;
  logic presetn;
  logic trust;
  int   checks = 0;
  int   fails  = 0;
  int   exp_last;

  tim3_apb_arb_if bus ();

  tim3_apb_arb #(.REJ_RDATA(REJ_VAL)) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .tipc_tim3_trust (trust),
    .bus             (bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // {pready_idx, pslverr_idx, pready_other, tim_psel, tim_penable}
  function automatic logic [4:0] ctl(input int idx);
    if (idx == 0) return {bus.m0_pready, bus.m0_pslverr, bus.m1_pready, bus.tim_psel, bus.tim_penable};
    return {bus.m1_pready, bus.m1_pslverr, bus.m0_pready, bus.tim_psel, bus.tim_penable};
  endfunction

  function automatic logic [31:0] rdata_of(input int idx);
    return (idx == 0) ? bus.m0_prdata : bus.m1_prdata;
  endfunction

  task automatic drive_req(input int idx, input logic en, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] prot);
    if (idx == 0) begin
      bus.m0_psel = en; bus.m0_penable = en; bus.m0_pwrite = wr;
      bus.m0_paddr = addr; bus.m0_pwdata = wdata; bus.m0_pprot = prot;
    end else begin
      bus.m1_psel = en; bus.m1_penable = en; bus.m1_pwrite = wr;
      bus.m1_paddr = addr; bus.m1_pwdata = wdata; bus.m1_pprot = prot;
    end
  endtask

  task automatic idle_inputs();
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    bus.tim_prdata = 32'h0;
  endtask

  // One isolated transfer; expectations come from the access rules, not the RTL
  task automatic do_xfer(input string nm, input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] prot, input logic tr,
                         input logic [31:0] rdata, input logic flip);
    logic        rej;
    logic [31:0] exp_rd;
    rej    = tr && prot[1];
    exp_rd = rej ? REJ_VAL : (wr ? 32'h0 : rdata);
    trust  = tr;
    drive_req(idx, 1'b1, wr, addr, wdata, prot);
    bus.tim_prdata = ~rdata;
    tick();
    if (flip) trust = ~tr;
    if (rej) begin
      checks++;
      if (ctl(idx) !== 5'b11000 || rdata_of(idx) !== exp_rd) begin
        $display("FAIL %s reject: ctl=%b prdata=%h want ctl=11000 prdata=%h", nm, ctl(idx), rdata_of(idx), exp_rd);
        fails++;
      end
      drive_req(idx, 1'b0, wr, addr, wdata, prot);
      tick();
      checks++;
      if (ctl(idx) !== 5'b00000 || rdata_of(idx) !== exp_rd) begin
        $display("FAIL %s reject_after: ctl=%b prdata=%h want ctl=00000 prdata=%h", nm, ctl(idx), rdata_of(idx), exp_rd);
        fails++;
      end
    end else begin
      checks++;
      if (ctl(idx) !== 5'b00010 || bus.tim_pwrite !== wr || bus.tim_paddr !== addr || bus.tim_pwdata !== wdata) begin
        $display("FAIL %s setup: ctl=%b wr=%b addr=%h wdata=%h want ctl=00010 wr=%b addr=%h wdata=%h",
                 nm, ctl(idx), bus.tim_pwrite, bus.tim_paddr, bus.tim_pwdata, wr, addr, wdata);
        fails++;
      end
      tick();
      checks++;
      if (ctl(idx) !== 5'b00011 || bus.tim_paddr !== addr || bus.tim_pwrite !== wr) begin
        $display("FAIL %s access: ctl=%b addr=%h wr=%b want ctl=00011 addr=%h wr=%b", nm, ctl(idx), bus.tim_paddr, bus.tim_pwrite, addr, wr);
        fails++;
      end
      bus.tim_prdata = rdata;
      tick();
      bus.tim_prdata = $urandom;
      checks++;
      if (ctl(idx) !== 5'b10000 || rdata_of(idx) !== exp_rd) begin
        $display("FAIL %s done: ctl=%b prdata=%h want ctl=10000 prdata=%h", nm, ctl(idx), rdata_of(idx), exp_rd);
        fails++;
      end
      drive_req(idx, 1'b0, wr, addr, wdata, prot);
      tick();
      checks++;
      if (ctl(idx) !== 5'b00000 || rdata_of(idx) !== exp_rd || bus.tim_paddr !== 32'h0) begin
        $display("FAIL %s hold: ctl=%b prdata=%h paddr=%h want ctl=00000 prdata=%h paddr=0", nm, ctl(idx), rdata_of(idx), bus.tim_paddr, exp_rd);
        fails++;
      end
    end
    exp_last = idx;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    trust   = 1'b0;
    idle_inputs();
    tick();
    drive_req(0, 1'b1, 1'b1, 32'h40, 32'h1, 3'b000);
    tick();
    tick();
    checks++;
    if ({bus.m0_pready, bus.m0_pslverr, bus.m1_pready, bus.m1_pslverr, bus.tim_psel, bus.tim_penable, bus.tim_pwrite} !== 7'b0) begin
      $display("FAIL reset_ctl: got %b want 0", {bus.m0_pready, bus.m0_pslverr, bus.m1_pready, bus.m1_pslverr,
               bus.tim_psel, bus.tim_penable, bus.tim_pwrite});
      fails++;
    end
    checks++;
    if (bus.m0_prdata !== 32'h0 || bus.m1_prdata !== 32'h0 || bus.tim_paddr !== 32'h0 || bus.tim_pwdata !== 32'h0) begin
      $display("FAIL reset_data: prdata0=%h prdata1=%h paddr=%h pwdata=%h want all 0", bus.m0_prdata, bus.m1_prdata, bus.tim_paddr, bus.tim_pwdata);
      fails++;
    end
    idle_inputs();
    presetn  = 1'b1;
    exp_last = 1;
    tick();
  endtask

  task automatic test_write_m0();
    do_xfer("m0_write", 0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b000, 1'b1, 32'h5A5A_0000, 1'b0);
  endtask

  task automatic test_read_m1();
    do_xfer("m1_read", 1, 1'b0, 32'h08, 32'h0, 3'b000, 1'b1, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_reject();
    do_xfer("m1_rej", 1, 1'b0, 32'h08, 32'h0, 3'b010, 1'b1, 32'h1111_2222, 1'b0);
    do_xfer("m1_ns_untrusted", 1, 1'b0, 32'h08, 32'h0, 3'b010, 1'b0, 32'h3333_4444, 1'b0);
    do_xfer("m0_rej_wr", 0, 1'b1, 32'h10, 32'hFFFF_0000, 3'b111, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic test_trust_change();
    do_xfer("trust_rise", 0, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'hA5A5_5A5A, 1'b1);
    do_xfer("trust_fall", 1, 1'b1, 32'h24, 32'h77, 3'b010, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_xfer("rand", int'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom,
              3'($urandom_range(0, 7)), 1'($urandom), $urandom, 1'($urandom));
    end
  endtask

  // Both requesters hold psel from reset; grants must alternate starting with m0
  task automatic test_back_to_back();
    int          exp_cyc, ncomp, exp_idx;
    logic [31:0] cur_rd;
    presetn = 1'b0;
    idle_inputs();
    tick();
    drive_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b000);
    drive_req(1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b000);
    trust    = 1'b0;
    presetn  = 1'b1;
    exp_last = 1;
    exp_cyc  = 3;
    ncomp    = 0;
    cur_rd   = 32'h0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (bus.m0_pready || bus.m1_pready) begin
        exp_idx = 1 - exp_last;
        checks++;
        if ({bus.m0_pready, bus.m1_pready} !== ((exp_idx == 1) ? 2'b01 : 2'b10) || cyc != exp_cyc || rdata_of(exp_idx) !== cur_rd) begin
          $display("FAIL b2b: cyc=%0d pready={%b,%b} prdata=%h want cyc=%0d m%0d prdata=%h",
                   cyc, bus.m0_pready, bus.m1_pready, rdata_of(exp_idx), exp_cyc, exp_idx, cur_rd);
          fails++;
        end
        exp_last = exp_idx;
        exp_cyc += 4;
        ncomp++;
      end
      cur_rd = $urandom;
      bus.tim_prdata = cur_rd;
    end
    checks++;
    if (ncomp != 5) begin
      $display("FAIL b2b_count: completions=%0d want 5", ncomp);
      fails++;
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_xfer("pre_rst", 1, 1'b0, 32'h08, 32'h0, 3'b000, 1'b0, 32'hCAFE_0001, 1'b0);
    drive_req(1, 1'b1, 1'b0, 32'h0C, 32'h0, 3'b000);
    tick();
    tick();
    checks++;
    if (ctl(1) !== 5'b00011) begin
      $display("FAIL rst_mid_access: ctl=%b want 00011", ctl(1));
      fails++;
    end
    presetn = 1'b0;
    drive_req(0, 1'b1, 1'b1, 32'h44, 32'h5555_AAAA, 3'b000);
    bus.tim_prdata = 32'h7777_7777;
    tick();
    checks++;
    if ({bus.m0_pready, bus.m1_pready, bus.tim_psel, bus.tim_penable} !== 4'b0 || bus.m1_prdata !== 32'h0) begin
      $display("FAIL rst_mid_abort: ctl=%b m1_prdata=%h want 0000 and 0",
               {bus.m0_pready, bus.m1_pready, bus.tim_psel, bus.tim_penable}, bus.m1_prdata);
      fails++;
    end
    presetn  = 1'b1;
    exp_last = 1;
    tick();
    checks++;
    if (bus.tim_psel !== 1'b1 || bus.tim_paddr !== 32'h44 || bus.tim_pwrite !== 1'b1) begin
      $display("FAIL rst_mid_regrant: psel=%b paddr=%h wr=%b want psel=1 paddr=00000044 wr=1", bus.tim_psel, bus.tim_paddr, bus.tim_pwrite);
      fails++;
    end
    tick();
    tick();
    checks++;
    if (ctl(0) !== 5'b10000 || bus.m0_prdata !== 32'h0) begin
      $display("FAIL rst_mid_done: ctl=%b prdata=%h want 10000 and 0", ctl(0), bus.m0_prdata);
      fails++;
    end
    exp_last = 0;
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_m1();
    test_reject();
    test_trust_change();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
